dh_exchange_ctrl: RTL and testbench
===================================

// Module: dh_exchange_ctrl
// PURPOSE
//  Sequences one shared modular-exponentiation engine (base^exp mod m) through a full
//  Diffie-Hellman exchange: R1=g^x mod p, R2=g^y mod p, K1=R2^x mod p, K2=R1^y mod p.
//  It then checks K1==K2. Sits between the top-level key-exchange wrapper and the modexp
//  datapath, and owns all engine operand muxing, handshaking and watchdog/error reporting.
// PARAMETERS
//  WIDTH        32    operand/result width (g, p, x, y, R1, R2, key)
//  TIMEOUT_CYC  1024  max cycles per engine job from me_start to me_done; 2..65535
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst        in   1      synchronous reset, active-high
//  st         in   1      start request; sampled only in IDLE
//  g          in   WIDTH  generator, latched on accepted st
//  p          in   WIDTH  modulus, latched on accepted st
//  x          in   WIDTH  party-1 secret, latched on accepted st
//  y          in   WIDTH  party-2 secret, latched on accepted st
//  me_start   out  1      one-cycle engine start pulse
//  me_base    out  WIDTH  engine base, held from me_start until me_done
//  me_exp     out  WIDTH  engine exponent, same hold rule
//  me_mod     out  WIDTH  engine modulus (= latched p)
//  me_done    in   1      engine result valid, one-cycle pulse
//  me_result  in   WIDTH  engine result, valid with me_done
//  r1         out  WIDTH  public value g^x mod p
//  r2         out  WIDTH  public value g^y mod p
//  key        out  WIDTH  shared key (K1)
//  busy       out  1      high from cycle after accepted st until done cycle, inclusive
//  done       out  1      one-cycle completion pulse
//  err        out  1      sticky error, valid from done pulse until next accepted st
//  err_code   out  2      0 none, 1 bad modulus (p<2), 2 engine timeout, 3 K1!=K2
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including r1, r2, key, me_* and err_code; timeout
//   counter is cleared. Reset mid-job aborts immediately, and any me_done arriving
//   afterwards is ignored.
//  FSM: IDLE -> CHK -> R1_REQ -> R1_WAIT -> R2_REQ -> R2_WAIT -> K1_REQ -> K1_WAIT
//   -> K2_REQ -> K2_WAIT -> CMP -> FIN -> IDLE.
//  IDLE: on st=1, latch g, p, x, y; clear r1, r2, key, err and err_code; go to CHK.
//   st while not in IDLE is ignored (no queuing).
//  CHK: if p<2, set err=1 and err_code=1 and go to FIN with no engine job. Else go to R1_REQ.
//  *_REQ: me_start=1 for exactly this cycle; load operands; clear timeout counter; go to *_WAIT.
//   Operands per job: R1 (g, x), R2 (g, y), K1 (r2, x), K2 (r1, y); me_mod=p for all jobs.
//  *_WAIT: hold operands. On me_done, capture me_result: R1->r1, R2->r2, K1->key, K2->k2
//   (internal), then advance. me_done in any non-WAIT state is ignored.
//   If the counter reaches TIMEOUT_CYC-1 with no me_done, set err_code=2 and go to FIN.
//   me_done in that same cycle wins over the timeout.
//  CMP: if key!=k2, set err=1 and err_code=3 (key still shows K1); go to FIN.
//  FIN: done=1 for one cycle, busy=1; return to IDLE. r1, r2, key, err and err_code hold
//   until the next accepted st.
//  Timing (engine latency N>=1, me_done N cycles after me_start): with st accepted at
//   edge k, the first me_start is in cycle k+2 and done is in cycle k+4N+7.
//   A bad-modulus job gives done in cycle k+2.
//  st held high continuously: a new job starts on the first IDLE cycle after FIN.
//  Arithmetic: equality compare only, no arithmetic in this block. Results are taken
//   unchanged from the engine; the engine reduces mod p.
// TESTING
//  Ideal engine N=3, g=5 p=23 x=6 y=15 -> r1=8 r2=19 key=2 err=0, done at k+19, 4 me_start pulses.
//  p=1 -> done at k+2, err_code=1, me_start never asserted, r1=r2=key=0.
//  Engine withholds me_done on the R2 job -> err_code=2 after TIMEOUT_CYC cycles in R2_WAIT;
//   r1=8 holds.
//  Engine corrupts the K2 result (returns 3) -> err_code=3, key=2, done pulses once.
//  rst during K1_WAIT, then a late me_done -> all outputs 0, IDLE, no capture. A following
//   st runs cleanly.
//  st pulsed during busy plus a stray me_done in IDLE -> both ignored; job results unchanged.

Source files
------------

// File: rtl/dh_exchange_ctrl_if.sv
// Host-side and modexp-engine-side signals of the Diffie-Hellman exchange controller.
// The controller connects through the slave modport; the host/engine side uses master.
interface dh_exchange_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             st;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             me_start;
    logic [WIDTH-1:0] me_base;
    logic [WIDTH-1:0] me_exp;
    logic [WIDTH-1:0] me_mod;
    logic             me_done;
    logic [WIDTH-1:0] me_result;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] key;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output st, g, p, x, y, me_done, me_result,
        input  me_start, me_base, me_exp, me_mod, r1, r2, key, busy, done, err, err_code
    );

    modport slave (
        input  st, g, p, x, y, me_done, me_result,
        output me_start, me_base, me_exp, me_mod, r1, r2, key, busy, done, err, err_code
    );
endinterface

// File: rtl/dh_exchange_ctrl.sv
// Drives one shared modexp engine through R1=g^x, R2=g^y, K1=R2^x, K2=R1^y (all mod p),
// compares K1 with K2 and reports bad modulus, engine timeout or key mismatch.
module dh_exchange_ctrl #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    dh_exchange_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHK     = 4'd1,
        S_R1_REQ  = 4'd2,
        S_R1_WAIT = 4'd3,
        S_R2_REQ  = 4'd4,
        S_R2_WAIT = 4'd5,
        S_K1_REQ  = 4'd6,
        S_K1_WAIT = 4'd7,
        S_K2_REQ  = 4'd8,
        S_K2_WAIT = 4'd9,
        S_CMP     = 4'd10,
        S_FIN     = 4'd11
    } state_t;

    localparam logic [15:0]      TO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [WIDTH-1:0] P_MIN   = WIDTH'(2);

    state_t           r_state;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_me_start;
    logic [WIDTH-1:0] r_me_base;
    logic [WIDTH-1:0] r_me_exp;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_k2;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [15:0]      r_cnt;
    logic             w_timeout;

    assign w_timeout = (r_cnt == TO_LAST);

    // Sequencer: every output is a register; me_start is high exactly while in a *_REQ state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_g        <= '0;
            r_p        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_me_start <= 1'b0;
            r_me_base  <= '0;
            r_me_exp   <= '0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_key      <= '0;
            r_k2       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_cnt      <= 16'd0;
        end else begin
            r_me_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.st) begin
                        r_g        <= bus.g;
                        r_p        <= bus.p;
                        r_x        <= bus.x;
                        r_y        <= bus.y;
                        r_r1       <= '0;
                        r_r2       <= '0;
                        r_key      <= '0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (r_p < P_MIN) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_me_start <= 1'b1;
                        r_me_base  <= r_g;
                        r_me_exp   <= r_x;
                        r_cnt      <= 16'd0;
                        r_state    <= S_R1_REQ;
                    end
                end
                S_R1_REQ: r_state <= S_R1_WAIT;
                S_R1_WAIT: begin
                    if (bus.me_done) begin
                        r_r1       <= bus.me_result;
                        r_me_start <= 1'b1;
                        r_me_base  <= r_g;
                        r_me_exp   <= r_y;
                        r_cnt      <= 16'd0;
                        r_state    <= S_R2_REQ;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_R2_REQ: r_state <= S_R2_WAIT;
                S_R2_WAIT: begin
                    // K1 uses R2 as its base, taken straight off the result bus.
                    if (bus.me_done) begin
                        r_r2       <= bus.me_result;
                        r_me_start <= 1'b1;
                        r_me_base  <= bus.me_result;
                        r_me_exp   <= r_x;
                        r_cnt      <= 16'd0;
                        r_state    <= S_K1_REQ;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_K1_REQ: r_state <= S_K1_WAIT;
                S_K1_WAIT: begin
                    if (bus.me_done) begin
                        r_key      <= bus.me_result;
                        r_me_start <= 1'b1;
                        r_me_base  <= r_r1;
                        r_me_exp   <= r_y;
                        r_cnt      <= 16'd0;
                        r_state    <= S_K2_REQ;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_K2_REQ: r_state <= S_K2_WAIT;
                S_K2_WAIT: begin
                    if (bus.me_done) begin
                        r_k2    <= bus.me_result;
                        r_state <= S_CMP;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CMP: begin
                    if (r_key != r_k2) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.me_start = r_me_start;
    assign bus.me_base  = r_me_base;
    assign bus.me_exp   = r_me_exp;
    assign bus.me_mod   = r_p;
    assign bus.r1       = r_r1;
    assign bus.r2       = r_r2;
    assign bus.key      = r_key;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Scoreboard bench for dh_exchange_ctrl with a behavioural modexp engine of configurable
// latency that can withhold or corrupt a chosen job.
module tb_dh_exchange_ctrl;
    localparam int W  = 32;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] key;
        logic [1:0]  code;
        int          lat;
        int          starts;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dh_exchange_ctrl_if #(.WIDTH(W)) ifc ();
    dh_exchange_ctrl #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;
    int   start_base = 0;
    exp_t sb_q[$];

    int          eng_lat      = 3;
    int          withhold_idx = -1;
    int          corrupt_idx  = -1;
    int          start_cnt    = 0;
    int          eng_cnt      = 0;
    logic        eng_done     = 1'b0;
    logic        eng_bad      = 1'b0;
    logic        stray_done   = 1'b0;
    logic [31:0] eng_result   = 32'd0;
    logic [31:0] eng_b        = 32'd0;
    logic [31:0] eng_e        = 32'd0;
    logic [31:0] eng_m        = 32'd0;

    assign ifc.me_done   = eng_done | stray_done;
    assign ifc.me_result = stray_done ? 32'hDEAD_BEEF : eng_result;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] acc;
        logic [63:0] bv;
        logic [63:0] m64;
        if (m == 32'd0) return 32'd0;
        m64 = {32'd0, m};
        acc = 64'd1 % m64;
        bv  = {32'd0, b} % m64;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) acc = (acc * bv) % m64;
            bv = (bv * bv) % m64;
        end
        return acc[31:0];
    endfunction

    // Engine model: me_done arrives eng_lat cycles after the me_start cycle; ignores rst.
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (ifc.me_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            if (start_cnt != withhold_idx) begin
                if (eng_lat == 1) begin
                    eng_done   <= 1'b1;
                    eng_result <= (start_cnt == corrupt_idx) ? 32'd3
                                  : modexp(ifc.me_base, ifc.me_exp, ifc.me_mod);
                end else begin
                    eng_cnt <= eng_lat - 1;
                    eng_b   <= ifc.me_base;
                    eng_e   <= ifc.me_exp;
                    eng_m   <= ifc.me_mod;
                    eng_bad <= (start_cnt == corrupt_idx);
                end
            end
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done   <= 1'b1;
                eng_result <= eng_bad ? 32'd3 : modexp(eng_b, eng_e, eng_m);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    task automatic expect_job(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] key,
                              input logic [1:0] code, input int lat, input int starts);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.key = key; e.code = code; e.lat = lat; e.starts = starts;
        sb_q.push_back(e);
    endtask

    task automatic start_job(input logic [31:0] g, input logic [31:0] p,
                             input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        ifc.g  = g;
        ifc.p  = p;
        ifc.x  = x;
        ifc.y  = y;
        ifc.st = 1'b1;
        start_base = start_cnt;
        @(negedge clk);
        ifc.st = 1'b0;
        accept_cyc = cyc;
        check_val("busy_after_st", {31'd0, ifc.busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (ifc.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done_seen"}, {31'd0, ifc.done}, 32'd1);
        if (sb_q.size() == 0) begin
            $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
            n_fail++;
            n_checks++;
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_latency"}, 32'(cyc - accept_cyc + 1), 32'(e.lat));
            check_val({tag, "_r1"}, ifc.r1, e.r1);
            check_val({tag, "_r2"}, ifc.r2, e.r2);
            check_val({tag, "_key"}, ifc.key, e.key);
            check_val({tag, "_err_code"}, {30'd0, ifc.err_code}, {30'd0, e.code});
            check_val({tag, "_err"}, {31'd0, ifc.err}, {31'd0, (e.code != 2'd0)});
            check_val({tag, "_me_starts"}, 32'(start_cnt - start_base), 32'(e.starts));
            check_val({tag, "_busy_at_done"}, {31'd0, ifc.busy}, 32'd1);
        end
        @(negedge clk);
        check_val({tag, "_done_once"}, {31'd0, ifc.done}, 32'd0);
        check_val({tag, "_busy_cleared"}, {31'd0, ifc.busy}, 32'd0);
    endtask

    initial begin
        int n;
        ifc.st = 1'b0;
        ifc.g  = 32'd0;
        ifc.p  = 32'd0;
        ifc.x  = 32'd0;
        ifc.y  = 32'd0;

        repeat (3) @(negedge clk);
        check_val("rst_r1", ifc.r1, 32'd0);
        check_val("rst_r2", ifc.r2, 32'd0);
        check_val("rst_key", ifc.key, 32'd0);
        check_val("rst_err_code", {30'd0, ifc.err_code}, 32'd0);
        check_val("rst_busy", {31'd0, ifc.busy}, 32'd0);
        check_val("rst_me_start", {31'd0, ifc.me_start}, 32'd0);
        check_val("rst_me_base", ifc.me_base, 32'd0);
        check_val("rst_me_mod", ifc.me_mod, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_done", {31'd0, ifc.done}, 32'd0);

        // Reference exchange, N=3.
        eng_lat = 3;
        expect_job(32'd8, 32'd19, 32'd2, 2'd0, 19, 4);
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        wait_done("basic");

        // Bad modulus: p=1 and p=0.
        expect_job(32'd0, 32'd0, 32'd0, 2'd1, 2, 0);
        start_job(32'd5, 32'd1, 32'd6, 32'd15);
        wait_done("p1");
        expect_job(32'd0, 32'd0, 32'd0, 2'd1, 2, 0);
        start_job(32'd5, 32'd0, 32'd6, 32'd15);
        wait_done("p0");

        // Engine withholds the R2 result.
        withhold_idx = start_cnt + 1;
        expect_job(32'd8, 32'd0, 32'd0, 2'd2, 3 + 4 + TO, 2);
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        wait_done("timeout_r2");
        withhold_idx = -1;

        // Engine corrupts K2.
        corrupt_idx = start_cnt + 3;
        expect_job(32'd8, 32'd19, 32'd2, 2'd3, 19, 4);
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        wait_done("k2_bad");
        corrupt_idx = -1;

        // Second operand set, N=1: 2^3=8, 2^4=5, 5^3=4, 8^4=4 (mod 11).
        eng_lat = 1;
        expect_job(32'd8, 32'd5, 32'd4, 2'd0, 11, 4);
        start_job(32'd2, 32'd11, 32'd3, 32'd4);
        wait_done("n1");

        // Reset during K1_WAIT; the engine's late me_done must be ignored.
        eng_lat = 5;
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        n = 0;
        while (start_cnt != start_base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_k1_started", 32'(start_cnt - start_base), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_r1", ifc.r1, 32'd0);
        check_val("abort_busy", {31'd0, ifc.busy}, 32'd0);
        check_val("abort_me_base", ifc.me_base, 32'd0);
        repeat (8) @(negedge clk);
        check_val("late_r1", ifc.r1, 32'd0);
        check_val("late_r2", ifc.r2, 32'd0);
        check_val("late_key", ifc.key, 32'd0);
        check_val("late_err_code", {30'd0, ifc.err_code}, 32'd0);
        check_val("late_busy", {31'd0, ifc.busy}, 32'd0);
        check_val("late_no_start", 32'(start_cnt - start_base), 32'd3);

        eng_lat = 3;
        expect_job(32'd8, 32'd19, 32'd2, 2'd0, 19, 4);
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        wait_done("after_abort");

        // st pulsed while busy, then a stray me_done while idle.
        expect_job(32'd8, 32'd19, 32'd2, 2'd0, 19, 4);
        start_job(32'd5, 32'd23, 32'd6, 32'd15);
        repeat (3) @(negedge clk);
        ifc.g  = 32'd7;
        ifc.p  = 32'd1;
        ifc.st = 1'b1;
        @(negedge clk);
        ifc.st = 1'b0;
        wait_done("st_busy");
        n = start_cnt;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check_val("stray_r1", ifc.r1, 32'd8);
        check_val("stray_r2", ifc.r2, 32'd19);
        check_val("stray_key", ifc.key, 32'd2);
        check_val("stray_err_code", {30'd0, ifc.err_code}, 32'd0);
        check_val("stray_busy", {31'd0, ifc.busy}, 32'd0);
        check_val("stray_no_start", 32'(start_cnt - n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
